sd_write_sequencer: RTL and testbench

SD_WRITE_SEQUENCER -- requirements
Module: sd_write_sequencer

---
 rtl/sd_wr_seq_pkg.sv | 35 +++
 rtl/sd_crc_status_rx.sv | 80 ++++++++
 rtl/sd_write_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_sd_write_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_wr_seq_pkg.sv
// -----------------------------------------------------------------------------
// sd_wr_seq_pkg
// Shared definitions for the SD multi-block write sequencer:
//   - seq_state_t  : sequencer FSM encoding
//   - seq_err_t    : ERROR output codes
//   - rx_state_t   : CRC status token receiver FSM encoding
//   - TOKEN_ACCEPT : CRC status token value meaning "data accepted"
// -----------------------------------------------------------------------------
package sd_wr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_STATUS   = 3'd2,
    ST_BUSYWAIT = 3'd3,
    ST_GAP      = 3'd4,
    ST_FINISH   = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CRC     = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ABORT   = 2'b11
  } seq_err_t;

  typedef enum logic [1:0] {
    RX_HUNT  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_HOLD  = 2'd2
  } rx_state_t;

  localparam logic [2:0] TOKEN_ACCEPT = 3'b010;

endpackage

// File: rtl/sd_crc_status_rx.sv
// -----------------------------------------------------------------------------
// sd_crc_status_rx
// Captures the 3-bit CRC status token the card returns on DAT0 after a block.
// While en is high it hunts for the DAT0=0 start bit, shifts the next three
// bits in MSB first, then pulses valid for one cycle with the token held on
// token. It then stays idle until en drops, so the busy-low level that follows
// the token is never mistaken for a new start bit.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   en     in   capture enable (high while the sequencer waits for status)
//   dat0   in   card DAT0 line
//   valid  out  one-cycle pulse, token is valid
//   token  out  captured token, MSB first
// -----------------------------------------------------------------------------
module sd_crc_status_rx
  import sd_wr_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dat0,
  output logic       valid,
  output logic [2:0] token
);

  localparam logic [1:0] LAST_BIT = 2'd2;

  rx_state_t  rx_state, rx_state_n;
  logic [1:0] bit_cnt;
  logic [2:0] shreg;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order-dependent
  // simulation and a mismatch against synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_HUNT;
    end else begin
      rx_state <= rx_state_n;
    end
  end

  // NOTE: next state gets a default before the case so every path assigns it;
  // a missing default in always_comb infers a latch.
  always_comb begin
    rx_state_n = rx_state;
    if (!en) begin
      rx_state_n = RX_HUNT;
    end else begin
      case (rx_state)
        RX_HUNT:  if (!dat0) rx_state_n = RX_SHIFT;
        RX_SHIFT: if (bit_cnt == LAST_BIT) rx_state_n = RX_HOLD;
        RX_HOLD:  rx_state_n = RX_HOLD;
        default:  rx_state_n = RX_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (en && rx_state == RX_SHIFT) begin
        shreg   <= {shreg[1:0], dat0};
        bit_cnt <= bit_cnt + 2'd1;
        if (bit_cnt == LAST_BIT) valid <= 1'b1;
      end else begin
        bit_cnt <= '0;
      end
    end
  end

  assign token = shreg;

endmodule

// File: rtl/sd_write_sequencer.sv
// -----------------------------------------------------------------------------
// sd_write_sequencer
// Sequences an SD multi-block write: for each block it enables the block data
// writer at the current buffer address, collects the card's CRC status token,
// waits out the card busy period, then opens a one-cycle gap so the writer
// restarts and advances the address by ADDR_STRIDE (11-bit wrap). ABORT is
// honoured only at block boundaries.
//
// Build option: define SD_WR_TIMEOUT_EN to add a watchdog on STATUS/BUSYWAIT
// that ends the run with ERROR=10 after TIMEOUT_CYCLES cycles in one state.
// Without it those states wait indefinitely.
//
// Parameters:
//   ADDR_STRIDE     buffer address advance per block (modulo 2048)
//   TIMEOUT_CYCLES  status/busy wait limit in clk cycles
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   start          in   pulse, begins a run (ignored unless idle)
//   block_count    in   number of blocks, sampled on start
//   base_addr      in   first block buffer address, sampled on start
//   abort          in   level, ends the run at the next block boundary
//   wr_ena         out  enable to the block data writer
//   wr_addr_begin  out  current block start address
//   wr_complt      in   data writer block-transmitted flag
//   sd_dat0        in   card DAT0 (CRC status token, busy)
//   busy           out  run in progress
//   done           out  one-cycle pulse at run end
//   error          out  00 none, 01 CRC rejected, 10 timeout, 11 aborted
//   blocks_done    out  card-accepted blocks this run
// -----------------------------------------------------------------------------
module sd_write_sequencer
  import sd_wr_seq_pkg::*;
#(
  parameter logic [10:0] ADDR_STRIDE    = 11'd1024,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] block_count,
  input  logic [10:0] base_addr,
  input  logic        abort,
  output logic        wr_ena,
  output logic [10:0] wr_addr_begin,
  input  logic        wr_complt,
  input  logic        sd_dat0,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error,
  output logic [15:0] blocks_done
);

  seq_state_t  state, state_n;
  seq_err_t    err_q, err_n;
  logic        err_we;
  logic        clr_run;
  logic        load_run;
  logic        inc_blk;
  logic        adv_addr;
  logic [15:0] run_count;
  logic        tok_valid;
  logic [2:0]  tok;
  logic        tmo_hit;

  sd_crc_status_rx u_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_STATUS),
    .dat0  (sd_dat0),
    .valid (tok_valid),
    .token (tok)
  );

`ifdef SD_WR_TIMEOUT_EN
  // Counts cycles spent in the current STATUS/BUSYWAIT visit; zero on the
  // first cycle of each visit.
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_n != state || !(state inside {ST_STATUS, ST_BUSYWAIT})) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th cycle of the visit.
  assign tmo_hit = (tmo_cnt == TIMEOUT_CYCLES - 16'd1);
`else
  // TIMEOUT_CYCLES only matters in the watchdog build.
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    err_we   = 1'b0;
    err_n    = ERR_NONE;
    clr_run  = 1'b0;
    load_run = 1'b0;
    inc_blk  = 1'b0;
    adv_addr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clr_run = 1'b1;
          if (block_count == 16'd0) begin
            state_n = ST_FINISH;
          end else begin
            load_run = 1'b1;
            state_n  = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (wr_complt) state_n = ST_STATUS;
      end
      ST_STATUS: begin
        if (tok_valid) begin
          if (tok == TOKEN_ACCEPT) begin
            state_n = ST_BUSYWAIT;
          end else begin
            state_n = ST_FINISH;
            err_we  = 1'b1;
            err_n   = ERR_CRC;
          end
        end else if (tmo_hit) begin
          state_n = ST_FINISH;
          err_we  = 1'b1;
          err_n   = ERR_TIMEOUT;
        end
      end
      ST_BUSYWAIT: begin
        if (sd_dat0) begin
          inc_blk = 1'b1;
          state_n = ST_GAP;
        end else if (tmo_hit) begin
          state_n = ST_FINISH;
          err_we  = 1'b1;
          err_n   = ERR_TIMEOUT;
        end
      end
      ST_GAP: begin
        // blocks_done already includes the block that just finished.
        adv_addr = 1'b1;
        if (blocks_done == run_count) begin
          state_n = ST_FINISH;
        end else if (abort) begin
          state_n = ST_FINISH;
          err_we  = 1'b1;
          err_n   = ERR_ABORT;
        end else begin
          state_n = ST_SEND;
        end
      end
      ST_FINISH: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_count     <= '0;
      wr_addr_begin <= '0;
      blocks_done   <= '0;
      err_q         <= ERR_NONE;
    end else begin
      if (clr_run) begin
        blocks_done <= '0;
        err_q       <= ERR_NONE;
      end
      if (load_run) begin
        run_count     <= block_count;
        wr_addr_begin <= base_addr;
      end
      if (inc_blk)  blocks_done   <= blocks_done + 16'd1;
      if (adv_addr) wr_addr_begin <= wr_addr_begin + ADDR_STRIDE;
      if (err_we)   err_q         <= err_n;
    end
  end

  // Decoded straight from the state register so reset drops them at once.
  assign wr_ena = (state == ST_SEND);
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_FINISH);
  assign error  = err_q;

endmodule

// File: tb/tb_sd_write_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sd_write_sequencer
// Directed bench for sd_write_sequencer. Expected block addresses and run
// results are queued when a run is launched and popped as the DUT opens each
// block and signals done. Inputs change and outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_sd_write_sequencer;
  import sd_wr_seq_pkg::*;

  typedef struct packed {
    logic [15:0] blocks;
    logic [1:0]  err;
  } result_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] block_count = '0;
  logic [10:0] base_addr = '0;
  logic        abort = 1'b0;
  logic        wr_complt = 1'b0;
  logic        sd_dat0 = 1'b1;
  logic        wr_ena;
  logic [10:0] wr_addr_begin;
  logic        busy;
  logic        done;
  logic [1:0]  error;
  logic [15:0] blocks_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_ena_cnt = 0;

  logic [10:0] addr_q[$];
  result_t     res_q[$];

  always #5 clk = ~clk;

  sd_write_sequencer #(
    .ADDR_STRIDE    (11'd1024),
    .TIMEOUT_CYCLES (16'd100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .block_count   (block_count),
    .base_addr     (base_addr),
    .abort         (abort),
    .wr_ena        (wr_ena),
    .wr_addr_begin (wr_addr_begin),
    .wr_complt     (wr_complt),
    .sd_dat0       (sd_dat0),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .blocks_done   (blocks_done)
  );

  always @(negedge clk) begin
    if (done)   done_cnt++;
    if (wr_ena) wr_ena_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_run(input logic [15:0] cnt, input logic [10:0] addr);
    block_count = cnt;
    base_addr   = addr;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    // Scramble the inputs to prove they were sampled on start.
    block_count = 16'hFFFF;
    base_addr   = ~addr;
    check("start_busy", busy, 1'b1);
    check("start_clr_err", error, ERR_NONE);
    check("start_clr_blocks", blocks_done, 16'd0);
  endtask

  task automatic wait_wr_ena(output bit ok);
    int waited = 0;
    while (!wr_ena && waited < 40) begin
      tick();
      waited++;
    end
    ok = wr_ena;
    check("wr_ena_rise", wr_ena, 1'b1);
  endtask

  // busy_len < 0 leaves DAT0 held low after the token.
  task automatic serve_block(input logic [2:0] tok, input int busy_len,
                             input bit accepted, input bit abort_mid);
    bit          ok;
    logic [10:0] exp_addr;
    wait_wr_ena(ok);
    if (!ok) return;
    check("addr_q_nonempty", addr_q.size() != 0, 1'b1);
    if (addr_q.size() == 0) return;
    exp_addr = addr_q.pop_front();
    check("wr_addr_begin", wr_addr_begin, exp_addr);
    if (abort_mid) abort = 1'b1;
    tick(2);
    check("addr_stable", wr_addr_begin, exp_addr);
    check("wr_ena_held", wr_ena, 1'b1);
    wr_complt = 1'b1;
    tick();
    wr_complt = 1'b0;
    check("wr_ena_drop", wr_ena, 1'b0);
    sd_dat0 = 1'b0;   tick();
    sd_dat0 = tok[2]; tick();
    sd_dat0 = tok[1]; tick();
    sd_dat0 = tok[0]; tick();
    if (accepted) begin
      sd_dat0 = 1'b0;
      if (busy_len < 0) return;
      tick(busy_len);
      sd_dat0 = 1'b1;
      tick();
      check("gap_wr_ena", wr_ena, 1'b0);
      check("gap_busy", busy, 1'b1);
    end else begin
      sd_dat0 = 1'b1;
    end
  endtask

  task automatic wait_done(output int waited);
    result_t exp;
    waited = 0;
    while (!done && waited < 300) begin
      tick();
      waited++;
    end
    check("done_seen", done, 1'b1);
    check("res_q_nonempty", res_q.size() != 0, 1'b1);
    if (!done || res_q.size() == 0) return;
    exp = res_q.pop_front();
    check("blocks_done", blocks_done, exp.blocks);
    check("error", error, exp.err);
    tick();
    check("done_one_cycle", done, 1'b0);
    check("busy_after_finish", busy, 1'b0);
    check("blocks_hold", blocks_done, exp.blocks);
    check("error_hold", error, exp.err);
  endtask

  initial begin
    int snap_done;
    int snap_wr;
    int w;
    bit ok;

    // Reset state
    tick(2);
    check("rst_wr_ena", wr_ena, 1'b0);
    check("rst_addr", wr_addr_begin, 11'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, ERR_NONE);
    check("rst_blocks", blocks_done, 16'd0);
    rst_n = 1'b1;
    tick(2);

    // Three blocks from address 0; stride wraps 1024+1024 to 0.
    addr_q.push_back(11'd0);
    addr_q.push_back(11'd1024);
    addr_q.push_back(11'd0);
    res_q.push_back(result_t'{blocks: 16'd3, err: ERR_NONE});
    snap_done = done_cnt;
    start_run(16'd3, 11'd0);
    // A start while busy must not restart or reload the run.
    block_count = 16'd7;
    base_addr   = 11'd5;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    serve_block(3'b010, 20, 1'b1, 1'b0);
    serve_block(3'b010, 20, 1'b1, 1'b0);
    serve_block(3'b010, 20, 1'b1, 1'b0);
    wait_done(w);
    check("run1_done_pulses", done_cnt - snap_done, 1);

    // Two blocks, second token rejected.
    addr_q.push_back(11'd100);
    addr_q.push_back(11'd1124);
    res_q.push_back(result_t'{blocks: 16'd1, err: ERR_CRC});
    start_run(16'd2, 11'd100);
    serve_block(3'b010, 5, 1'b1, 1'b0);
    serve_block(3'b101, 0, 1'b0, 1'b0);
    wait_done(w);

    // Four blocks, abort raised during block 2.
    addr_q.push_back(11'd2000);
    addr_q.push_back(11'd976);
    res_q.push_back(result_t'{blocks: 16'd2, err: ERR_ABORT});
    start_run(16'd4, 11'd2000);
    serve_block(3'b010, 3, 1'b1, 1'b0);
    serve_block(3'b010, 3, 1'b1, 1'b1);
    wait_done(w);
    abort = 1'b0;
    tick();

    // Zero blocks: done the cycle after start, writer never enabled.
    res_q.push_back(result_t'{blocks: 16'd0, err: ERR_NONE});
    snap_wr   = wr_ena_cnt;
    snap_done = done_cnt;
    start_run(16'd0, 11'd7);
    wait_done(w);
    check("zero_done_latency", w, 0);
    check("zero_no_wr_ena", wr_ena_cnt - snap_wr, 0);
    check("zero_done_pulses", done_cnt - snap_done, 1);

    // DAT0 stuck low in busy.
    addr_q.push_back(11'd0);
    snap_done = done_cnt;
    start_run(16'd1, 11'd0);
    serve_block(3'b010, -1, 1'b1, 1'b0);
`ifdef SD_WR_TIMEOUT_EN
    res_q.push_back(result_t'{blocks: 16'd0, err: ERR_TIMEOUT});
    wait_done(w);
    check("timeout_latency", w, 101);
`else
    tick(150);
    check("stuck_busy", busy, 1'b1);
    check("stuck_no_done", done_cnt - snap_done, 0);
    check("stuck_error", error, ERR_NONE);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif
    sd_dat0 = 1'b1;
    tick(2);

    // Reset in the middle of SEND.
    snap_done = done_cnt;
    start_run(16'd2, 11'd300);
    wait_wr_ena(ok);
    check("rstmid_addr", wr_addr_begin, 11'd300);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_wr_ena", wr_ena, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_addr_clr", wr_addr_begin, 11'd0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("rstmid_no_done", done_cnt - snap_done, 0);
    check("rstmid_idle", busy, 1'b0);

    check("addr_q_drained", addr_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
